// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
//
// Sequential AES MixColumns engine. A 128-bit state is captured over a
// valid/ready handshake, then one result byte is produced per clock using a
// single shared xtime (GF(2^8) multiply-by-2) stage. After 16 bytes the
// result is presented on a valid/ready output port and held until taken.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   in_state is valid
//   in_ready   block can accept a state (high only while idle)
//   in_state   input state, byte i = in_state[127-8i -: 8]
//   out_valid  out_state holds a completed result
//   out_ready  consumer accepts out_state
//   out_state  MixColumns result, registered
//   busy       high while computing or holding a result
// ---------------------------------------------------------------------------
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] cap_q [16];
  logic [7:0] res_q [16];

  // Byte datapath: cnt_q selects column (cnt[3:2]) and row (cnt[1:0]); the
  // other three operands are the same column's bytes rotated by 1..3 rows.
  logic [1:0] col;
  logic [1:0] row1;
  logic [1:0] row2;
  logic [1:0] row3;
  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] a2;
  logic [7:0] a3;
  logic [7:0] x_in;
  logic [7:0] x_out;
  logic [7:0] byte_d;

  assign col  = cnt_q[3:2];
  assign row1 = cnt_q[1:0] + 2'd1;
  assign row2 = cnt_q[1:0] + 2'd2;
  assign row3 = cnt_q[1:0] + 2'd3;

  assign a0 = cap_q[cnt_q];
  assign a1 = cap_q[{col, row1}];
  assign a2 = cap_q[{col, row2}];
  assign a3 = cap_q[{col, row3}];

  // 2*a0 ^ 3*a1 == xtime(a0 ^ a1) ^ a1, so one xtime covers both products.
  assign x_in   = a0 ^ a1;
  assign x_out  = {x_in[6:0], 1'b0} ^ (x_in[7] ? 8'h1B : 8'h00);
  assign byte_d = x_out ^ a1 ^ a2 ^ a3;

  // Control FSM with byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Input capture; only loaded on acceptance so later in_state changes are
  // invisible to the computation.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      for (int i = 0; i < 16; i++) begin
        cap_q[i] <= in_state[127-8*i -: 8];
      end
    end
  end

  // Result register, written one byte per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        res_q[i] <= 8'h00;
      end
    end else if (state_q == RUN) begin
      res_q[cnt_q] <= byte_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_out
      assign out_state[127-8*gi -: 8] = res_q[gi];
    end
  endgenerate

  // Handshake flags decode the registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);

endmodule
